// File: rtl/symmetric_pattern_gen.sv
// symmetric_pattern_gen
// Emits a burst of mirrored bytes over a valid/ready stream. Each byte is
// built from a 4-bit half-pattern h: the low nibble is h, the high nibble is
// h bit-reversed, optionally XOR-corrupted per mirrored pair by a latched mask.
// Alongside the data it reports the symmetry flag and mismatch count that a
// symmetry detector should produce for every byte of the burst.
module symmetric_pattern_gen #(
  parameter logic [3:0] SEED = 4'h1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic [3:0] half_in,
  input  logic [3:0] err_mask,
  input  logic [7:0] num_bytes,
  input  logic       ready,
  output logic [7:0] data,
  output logic       valid,
  output logic       exp_sym,
  output logic [2:0] exp_mismatch,
  output logic [7:0] seq_cnt,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] MODE_FIXED = 2'd0;
  localparam logic [1:0] MODE_COUNT = 2'd1;
  localparam logic [1:0] MODE_LFSR  = 2'd2;
  localparam logic [1:0] MODE_WALK  = 2'd3;

  // An all-zero LFSR state would lock up, so a zero seed falls back to 1.
  localparam logic [3:0] SEED_EFF = (SEED == 4'h0) ? 4'h1 : SEED;

  // Number of set bits in a nibble (0..4).
  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // Mirrored byte: low nibble is h, bit 7-k carries h[k] flipped by m[k].
  function automatic logic [7:0] form_byte(input logic [3:0] h, input logic [3:0] m);
    form_byte = {h[0] ^ m[0], h[1] ^ m[1], h[2] ^ m[2], h[3] ^ m[3], h};
  endfunction

  // Latched burst configuration
  state_t     state_r;
  logic [1:0] mode_r;
  logic [3:0] half_r;
  logic [3:0] mask_r;
  logic [7:0] num_r;

  // Running half-pattern and registered outputs
  logic [3:0] h_r;
  logic [7:0] data_r;
  logic       valid_r;
  logic       exp_sym_r;
  logic [2:0] exp_mismatch_r;
  logic [7:0] seq_cnt_r;
  logic       busy_r;
  logic       done_r;

  // Combinational helpers
  logic [3:0] init_h_s;
  logic [3:0] next_h_s;
  logic       xfer_s;
  logic       last_s;

  assign data         = data_r;
  assign valid        = valid_r;
  assign exp_sym      = exp_sym_r;
  assign exp_mismatch = exp_mismatch_r;
  assign seq_cnt      = seq_cnt_r;
  assign busy         = busy_r;
  assign done         = done_r;

  // Pick the first half-pattern of the burst from the latched value and mode.
  always_comb begin
    init_h_s = half_r;
    case (mode_r)
      MODE_FIXED: init_h_s = half_r;
      MODE_COUNT: init_h_s = half_r;
      MODE_LFSR: begin
        if (half_r == 4'h0) begin
          init_h_s = SEED_EFF;
        end else begin
          init_h_s = half_r;
        end
      end
      MODE_WALK: begin
        if (popcount4(half_r) == 3'd1) begin
          init_h_s = half_r;
        end else begin
          init_h_s = 4'b0001;
        end
      end
      default: init_h_s = half_r;
    endcase
  end

  // Advance the half-pattern by one step of the latched mode.
  always_comb begin
    next_h_s = h_r;
    case (mode_r)
      MODE_FIXED: next_h_s = h_r;
      MODE_COUNT: next_h_s = h_r + 4'd1;
      MODE_LFSR:  next_h_s = {h_r[2:0], h_r[3] ^ h_r[2]};
      MODE_WALK:  next_h_s = {h_r[2:0], h_r[3]};
      default:    next_h_s = h_r;
    endcase
  end

  // Handshake decode; num_r of 0 wraps to 255 so a 256-byte burst ends on index 255.
  always_comb begin
    xfer_s = valid_r & ready;
    last_s = (seq_cnt_r == (num_r - 8'd1));
  end

  // Burst sequencer with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      mode_r         <= 2'd0;
      half_r         <= 4'h0;
      mask_r         <= 4'h0;
      num_r          <= 8'd0;
      h_r            <= 4'h0;
      data_r         <= 8'h00;
      valid_r        <= 1'b0;
      exp_sym_r      <= 1'b0;
      exp_mismatch_r <= 3'd0;
      seq_cnt_r      <= 8'd0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // Configuration is captured as start is accepted so that the
          // LOAD cycle works from a stable copy regardless of later inputs.
          if (start) begin
            mode_r         <= mode;
            half_r         <= half_in;
            mask_r         <= err_mask;
            num_r          <= num_bytes;
            exp_sym_r      <= (err_mask == 4'h0);
            exp_mismatch_r <= popcount4(err_mask);
            seq_cnt_r      <= 8'd0;
            busy_r         <= 1'b1;
            state_r        <= ST_LOAD;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          h_r       <= init_h_s;
          data_r    <= form_byte(init_h_s, mask_r);
          seq_cnt_r <= 8'd0;
          valid_r   <= 1'b1;
          busy_r    <= 1'b1;
          state_r   <= ST_SEND;
        end
        ST_SEND: begin
          if (xfer_s) begin
            seq_cnt_r <= seq_cnt_r + 8'd1;
            h_r       <= next_h_s;
            if (last_s) begin
              data_r  <= 8'h00;
              valid_r <= 1'b0;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              data_r  <= form_byte(next_h_s, mask_r);
              state_r <= ST_SEND;
            end
          end else begin
            state_r <= ST_SEND;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_symmetric_pattern_gen.sv
// Self-checking bench for symmetric_pattern_gen: directed bursts plus random
// bursts, each compared against a byte list computed from the pattern rules.
module tb_symmetric_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic [3:0] half_in;
  logic [3:0] err_mask;
  logic [7:0] num_bytes;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       exp_sym;
  logic [2:0] exp_mismatch;
  logic [7:0] seq_cnt;
  logic       busy;
  logic       done;

  int test_cnt = 0;
  int fail_cnt = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  symmetric_pattern_gen dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .mode         (mode),
    .half_in      (half_in),
    .err_mask     (err_mask),
    .num_bytes    (num_bytes),
    .ready        (ready),
    .data         (data),
    .valid        (valid),
    .exp_sym      (exp_sym),
    .exp_mismatch (exp_mismatch),
    .seq_cnt      (seq_cnt),
    .busy         (busy),
    .done         (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    test_cnt++;
    if (got !== want) begin
      fail_cnt++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference: byte value from half-pattern h and mask m.
  function automatic int ref_byte(input int h, input int m);
    int b;
    b = h;
    for (int k = 0; k < 4; k++) begin
      if ((((h >> k) ^ (m >> k)) & 1) != 0) b += (1 << (7 - k));
    end
    return b;
  endfunction

  function automatic int ref_init(input int md, input int hv);
    if (md == 2) return (hv == 0) ? 1 : hv;
    if (md == 3) return (hv == 1 || hv == 2 || hv == 4 || hv == 8) ? hv : 1;
    return hv;
  endfunction

  function automatic int ref_next(input int md, input int h);
    case (md)
      1: return (h + 1) % 16;
      2: return ((h * 2) % 16) + (((h >> 3) & 1) ^ ((h >> 2) & 1));
      3: return ((h * 2) % 16) + (h / 8);
      default: return h;
    endcase
  endfunction

  function automatic int ref_pop(input int m);
    int c;
    c = 0;
    for (int k = 0; k < 4; k++) c += (m >> k) & 1;
    return c;
  endfunction

  // rdy_mode: 0 always ready, 1 random, 2 low for the first 3 valid cycles.
  task automatic run_burst(input int md, input int hv, input int mk, input int nb,
                           input int rdy_mode, input bit poke_start);
    int n;
    int h;
    int idx;
    int cyc;
    int budget;
    bit r;
    n = (nb == 0) ? 256 : nb;
    exp_q.delete();
    h = ref_init(md, hv);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(ref_byte(h, mk));
      h = ref_next(md, h);
    end

    @(negedge clk);
    check_eq("idle_done", done, 0);
    check_eq("idle_busy", busy, 0);
    mode = md[1:0]; half_in = hv[3:0]; err_mask = mk[3:0]; num_bytes = nb[7:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode = 2'($urandom); half_in = 4'($urandom); err_mask = 4'($urandom);
    num_bytes = 8'($urandom);
    check_eq("load_busy", busy, 1);
    check_eq("load_valid", valid, 0);

    idx = 0;
    cyc = 0;
    budget = 8 * n + 50;
    @(negedge clk);
    while (idx < n && cyc < budget) begin
      check_eq("send_valid", valid, 1);
      check_eq("send_busy", busy, 1);
      check_eq("send_done", done, 0);
      check_eq("data", data, exp_q[idx]);
      check_eq("seq_cnt", seq_cnt, idx % 256);
      check_eq("exp_sym", exp_sym, (mk == 0) ? 1 : 0);
      check_eq("exp_mismatch", exp_mismatch, ref_pop(mk));
      case (rdy_mode)
        1: r = 1'($urandom_range(0, 1));
        2: r = (cyc >= 3);
        default: r = 1'b1;
      endcase
      ready = r;
      start = poke_start && (cyc == 1);
      if (poke_start && cyc == 1) begin
        half_in = 4'($urandom); num_bytes = 8'($urandom); mode = 2'($urandom);
      end
      if (valid && r) idx++;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    check_eq("xfer_count", idx, n);
    check_eq("done_pulse", done, 1);
    check_eq("done_valid", valid, 0);
    check_eq("done_busy", busy, 0);
    check_eq("done_exp_sym", exp_sym, (mk == 0) ? 1 : 0);
    check_eq("done_exp_mismatch", exp_mismatch, ref_pop(mk));
    ready = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'd0; half_in = 4'h0; err_mask = 4'h0;
    num_bytes = 8'd0; ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_data", data, 0);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_seq", seq_cnt, 0);
    check_eq("rst_exp_sym", exp_sym, 0);
    check_eq("rst_exp_mm", exp_mismatch, 0);
    rst = 1'b0;

    run_burst(0, 4'hB, 4'h0, 2, 0, 1'b0);   // fixed, symmetric
    run_burst(0, 4'hB, 4'h1, 1, 0, 1'b0);   // one corrupted pair
    run_burst(0, 4'hB, 4'hF, 1, 0, 1'b0);   // all pairs corrupted
    run_burst(1, 4'hE, 4'h0, 3, 0, 1'b0);   // count wrap
    run_burst(2, 4'h0, 4'h0, 4, 0, 1'b0);   // LFSR from seed
    run_burst(2, 4'h0, 4'h0, 0, 0, 1'b0);   // 256-byte burst
    run_burst(1, 4'hE, 4'h0, 3, 2, 1'b1);   // back-pressure, start ignored
    run_burst(3, 4'h6, 4'h0, 6, 0, 1'b0);   // walking-one, invalid start value

    // Reset mid-burst aborts with no done pulse.
    @(negedge clk);
    mode = 2'd1; half_in = 4'h3; err_mask = 4'h2; num_bytes = 8'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0; ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("pre_rst_seq", seq_cnt, 1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", valid, 0);
    check_eq("mid_rst_data", data, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_exp_mm", exp_mismatch, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("post_rst_done", done, 0);
      check_eq("post_rst_valid", valid, 0);
    end
    run_burst(3, 4'h4, 4'h5, 6, 1, 1'b1);

    for (int t = 0; t < 25; t++) begin
      run_burst($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15),
                $urandom_range(1, 12), 1, 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    check_eq("final_done", done, 0);
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
